cpu_run_ctrl: RTL

- Run/halt/single-step/breakpoint sequencer for the single-cycle RISC-V core.
- Sits between the clock divider tick and the datapath.
- Emits a one-cycle `cpu_en` strobe that gates every architectural state update: PC, RF write, DM write.
- Replaces the free-running divided CPU clock: the core runs on `clk`, advancing only when `cpu_en` is high.
- Exposes state, halt cause and a retired-instruction count for the seg7 debug display.

---
 rtl/cpu_run_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/single-step/breakpoint sequencer for the single-cycle core
//
// Purpose: issues a registered one-cycle cpu_en strobe per instruction to execute.
//   The core runs on clk and updates PC, RF and DM only while cpu_en is high.
//
// Optional feature: define CPU_RUN_CTRL_LIMIT_EN to add a free-run instruction budget.
//   The budget is RUN_LIMIT instructions per entry into RUN.
//   When it is used up, the next tick breaks with halt_cause=10.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tick       in   divider pulse, execution rate while running
//   run_sw     in   level, 1 requests free run
//   step_btn   in   debounced level, rising edge requests one instruction
//   bp_en      in   breakpoint enable
//   bp_addr    in   breakpoint instruction index
//   pc         in   current instruction index from fetch
//   cpu_en     out  one-cycle execute strobe (registered)
//   state_o    out  00 HALT, 01 RUN, 10 STEP, 11 BREAK
//   halt_cause out  00 manual/none, 01 breakpoint, 10 limit
//   retired    out  count of cpu_en pulses since reset, wraps
module cpu_run_ctrl #(
    parameter int          PC_W      = 8,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] RUN_LIMIT = 16'd100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic [1:0]       state_o,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_e;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_BP    = 2'b01;
    localparam logic [1:0] CAUSE_LIMIT = 2'b10;

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic             cpu_en_q, cpu_en_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             step_q;

    logic step_edge;
    logic bp_hit;
    logic limit_hit;

    assign step_edge = step_btn & ~step_q;
    // The breakpoint is only acted on when an instruction would otherwise issue.
    assign bp_hit    = tick & bp_en & (pc == bp_addr);

`ifdef CPU_RUN_CTRL_LIMIT_EN
    logic [15:0] run_cnt_q, run_cnt_d;

    // Counts instructions issued in the current free-run session only.
    // STEP strobes are issued from the STEP state, so they never count here.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (state_d == ST_RUN && state_q != ST_RUN) begin
            run_cnt_d = 16'd0;
        end else if (state_q == ST_RUN && cpu_en_d) begin
            run_cnt_d = run_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= 16'd0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    assign limit_hit = tick & (run_cnt_q == RUN_LIMIT);
`else
    logic unused_limit;
    assign unused_limit = ^RUN_LIMIT;
    assign limit_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cpu_en_d  = 1'b0;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, cpu_en_q};

        unique case (state_q)
            ST_HALT: begin
                if (run_sw) begin
                    state_d = ST_RUN;
                    cause_d = CAUSE_NONE;
                end else if (step_edge) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_sw) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_NONE;
                end else if (bp_hit) begin
                    state_d = ST_BREAK;
                    cause_d = CAUSE_BP;
                end else if (limit_hit) begin
                    state_d = ST_BREAK;
                    cause_d = CAUSE_LIMIT;
                end else if (tick) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: begin
                // The step strobe is already out; this cycle only picks the follow-on state.
                state_d = run_sw ? ST_RUN : ST_HALT;
            end
            ST_BREAK: begin
                // Leaving a break to resume execution always goes through a step,
                // so the breakpoint instruction itself gets executed.
                if (step_edge) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end else if (!run_sw) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HALT;
            cause_q   <= CAUSE_NONE;
            cpu_en_q  <= 1'b0;
            retired_q <= '0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cpu_en_q  <= cpu_en_d;
            retired_q <= retired_d;
            step_q    <= step_btn;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign state_o    = state_q;
    assign halt_cause = cause_q;
    assign retired    = retired_q;

endmodule
